// File: rtl/dip_pkg.sv
// Shared DIP word type and debounce defaults, used by the reader, this filter
// and the LED / seven-segment drivers.
package dip_pkg;

    localparam int DIP_WIDTH        = 16;
    localparam int DIP_STABLE_COUNT = 4;
    localparam int DIP_TIMEOUT_CYC  = 65536;

    typedef logic [DIP_WIDTH-1:0] dip_word_t;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int sat_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dip_debounce_filter_sat_timer.sv
// Saturating up-counter with synchronous clear; done is high while the count
// sits at MAX_COUNT.
module sat_timer
    import dip_pkg::*;
#(
    parameter int MAX_COUNT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    localparam int CW = sat_width(MAX_COUNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_COUNT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == CNT_MAX);

endmodule

// File: rtl/dip_debounce_filter.sv
// Debounces parallel DIP frames: a value is published once STABLE_COUNT
// consecutive identical frames arrive; also reports a stale reader.
module dip_debounce_filter
    import dip_pkg::*;
#(
    parameter int WIDTH        = DIP_WIDTH,
    parameter int STABLE_COUNT = DIP_STABLE_COUNT,
    parameter int TIMEOUT_CYC  = DIP_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_data,
    input  logic             raw_valid,
    output logic [WIDTH-1:0] stable_data,
    output logic             stable_valid,
    output logic             changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             stale
);

    localparam int RUN_W = sat_width(STABLE_COUNT);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(STABLE_COUNT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [WIDTH-1:0] cand, cand_next;
    logic [RUN_W-1:0] run, run_next;
    logic             frame_match;
    logic             accept;
    logic             publish;

    always_comb begin
        cand_next   = cand;
        run_next    = run;
        accept      = 1'b0;
        frame_match = (run != '0) && (raw_data == cand);
        if (raw_valid) begin
            if (frame_match) begin
                if (run != RUN_SAT) begin
                    run_next = run + RUN_ONE;
                end
            end else begin
                cand_next = raw_data;
                run_next  = RUN_ONE;
            end
            // A fresh run that saturates immediately (STABLE_COUNT=1) also counts.
            accept = (run_next == RUN_SAT) && ((run != RUN_SAT) || !frame_match);
        end
        publish = accept && (!stable_valid || (cand_next != stable_data));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand         <= '0;
            run          <= '0;
            stable_data  <= '0;
            stable_valid <= 1'b0;
            changed      <= 1'b0;
            changed_mask <= '0;
        end else begin
            cand    <= cand_next;
            run     <= run_next;
            changed <= publish;
            if (publish) begin
                stable_data  <= cand_next;
                changed_mask <= stable_data ^ cand_next;
                stable_valid <= 1'b1;
            end
        end
    end

    sat_timer #(
        .MAX_COUNT (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (raw_valid),
        .done  (stale)
    );

endmodule
